mux_n_scan: RTL and testbench
=============================

MUX_N_SCAN -- requirements
Module: mux_n_scan

Interface
REQ-001 SHALL have parameter N, default 8: number of input channels, legal range 2..64.
REQ-002 SHALL have parameter W, default 1: width of each channel in bits, legal range 1..32.
REQ-003 SHALL have derived parameter SW = max(1, clog2(N)): width of channel indices.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 d  input  N*W  flattened channel data; channel k occupies bits [k*W +: W].
REQ-007 sel  input  SW  channel select, used in static mode.
REQ-008 mode  input  1  0 = static select, 1 = scan sequencer.
REQ-009 start  input  1  in scan mode, requests one sweep of channels 0..N-1.
REQ-010 out_ready  input  1  downstream accept; a transfer occurs when y_valid and out_ready are both 1 on a clock edge.
REQ-011 y  output  W  registered selected channel data.
REQ-012 y_valid  output  1  y, y_ch are valid.
REQ-013 y_ch  output  SW  index of the channel currently on y.
REQ-014 busy  output  1  high while a scan sweep is in progress.
REQ-015 done  output  1  one-cycle pulse when a sweep completes.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN, DONE; the FSM is used only when mode=1.
REQ-017 Static mode (mode=0), FSM in IDLE: when y_valid=0 or out_ready=1, SHALL register y <= d[sel], y_ch <= sel, y_valid <= 1; otherwise y, y_ch, y_valid SHALL hold (one-cycle latency, no combinational path d->y).
REQ-018 Static mode, sel >= N: SHALL register y <= 0, y_ch <= sel, y_valid <= 1.
REQ-019 Scan mode, IDLE, y_valid=0: y_valid SHALL stay 0 and y, y_ch SHALL hold; start=1 SHALL move to SCAN and clear the internal index idx to 0.
REQ-020 Scan mode, IDLE, y_valid=1: a transfer (out_ready=1) SHALL clear y_valid to 0; without one, y, y_ch, y_valid SHALL hold.
REQ-021 Scan mode, IDLE: start=1 with y_valid=1 and out_ready=0 SHALL still enter SCAN; the pending beat SHALL hold until transferred.
REQ-022 SCAN: when y_valid=0 or out_ready=1, SHALL load y <= d[idx], y_ch <= idx, y_valid <= 1; if idx = N-1 SHALL go to DONE, else idx <= idx+1.
REQ-023 SCAN with y_valid=1 and out_ready=0 (back-pressure): y, y_ch, y_valid and idx SHALL hold.
REQ-024 DONE: done SHALL be 1 for exactly this one cycle; SHALL return to IDLE next cycle.
REQ-025 In DONE the last beat (channel N-1) SHALL be held until transferred; y_valid SHALL drop only after that transfer.
REQ-026 busy SHALL be 1 exactly in SCAN and DONE.
REQ-027 start while in SCAN or DONE SHALL be ignored (no restart, no queuing).
REQ-028 mode 1->0 during SCAN or DONE SHALL abort to IDLE next cycle; done SHALL not pulse; static operation SHALL resume per REQ-017.
REQ-029 d SHALL be sampled at the load edge; changes of d while a beat is held SHALL not alter y.
REQ-030 idx SHALL never exceed N-1; no wrap within a sweep.

Reset
REQ-031 rst=1 at a clock edge SHALL force FSM to IDLE, idx=0, y=0, y_ch=0, y_valid=0, busy=0, done=0, overriding all other inputs.
REQ-032 rst asserted mid-sweep SHALL discard the sweep; no done pulse.
REQ-033 In the first cycle after rst deasserts, outputs SHALL still show reset values; loading per REQ-017..REQ-022 starts on the first edge with rst=0.

Verification
REQ-034 N=8, W=1, mode=0, out_ready=1, d=8'b1010_0110, sel stepping 0..7 -> y one cycle later = 0,1,1,0,0,1,0,1 with y_ch = sel.
REQ-035 N=4, W=8, mode=1, d={8'h44,8'h33,8'h22,8'h11}, start pulse, out_ready=1 -> y = 11,22,33,44 on consecutive cycles, y_ch 0..3, busy=1 over the sweep, done pulses once, then y_valid=0 after the last transfer.
REQ-036 Same setup with out_ready=0 for 3 cycles while y=8'h22 -> y and y_ch=1 hold, then sweep resumes with 33, 44; no beat dropped or duplicated.
REQ-037 start pulsed again mid-sweep -> ignored; exactly N beats and one done.
REQ-038 rst asserted on the 2nd scan beat -> next cycle all outputs 0, state IDLE, no done; mode=0, sel=9, N=8 -> y=0, y_valid=1.

Source files
------------

// File: rtl/mux_n_scan.sv
// mux_n_scan: N-channel registered multiplexer with a one-shot scan sequencer.
// Output beats use a valid/ready handshake, and a beat that has not been accepted is held.
`default_nettype none

module mux_n_scan #(
  parameter int N  = 8,
  parameter int W  = 1,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*W-1:0]    d,
  input  logic [SW-1:0]     sel,
  input  logic              mode,
  input  logic              start,
  input  logic              out_ready,
  output logic [W-1:0]      y,
  output logic              y_valid,
  output logic [SW-1:0]     y_ch,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [SW-1:0] LAST = SW'(N - 1);

  state_t          state, state_n;
  logic [SW-1:0]   idx, idx_n;
  logic [W-1:0]    y_n;
  logic [SW-1:0]   y_ch_n;
  logic            y_valid_n;
  logic [W-1:0]    sel_data;
  logic [W-1:0]    idx_data;
  logic            take;

  // Both lookups fall through to zero when the index matches no channel.
  always_comb begin
    sel_data = '0;
    idx_data = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SW'(k)) sel_data = d[k*W +: W];
      if (idx == SW'(k)) idx_data = d[k*W +: W];
    end
  end

  // The output register may be (re)loaded when empty or when its beat leaves this edge.
  assign take = !y_valid || out_ready;

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    y_n       = y;
    y_ch_n    = y_ch;
    y_valid_n = y_valid;
    case (state)
      IDLE: begin
        if (!mode) begin
          if (take) begin
            y_n       = sel_data;
            y_ch_n    = sel;
            y_valid_n = 1'b1;
          end
        end else begin
          if (y_valid && out_ready) y_valid_n = 1'b0;
          if (start) begin
            state_n = SCAN;
            idx_n   = '0;
          end
        end
      end
      SCAN: begin
        if (!mode) begin
          // Abort: the pending beat still leaves if accepted, but no new one loads.
          state_n = IDLE;
          if (y_valid && out_ready) y_valid_n = 1'b0;
        end else if (take) begin
          y_n       = idx_data;
          y_ch_n    = idx;
          y_valid_n = 1'b1;
          if (idx == LAST) state_n = DONE;
          else             idx_n   = idx + SW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        if (y_valid && out_ready) y_valid_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      y       <= y_n;
      y_ch    <= y_ch_n;
      y_valid <= y_valid_n;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_mux_n_scan.sv
// Self-checking bench for mux_n_scan: static selection, scan sweeps, back-pressure, abort and reset.
`default_nettype none

module tb_mux_n_scan;

  logic clk;
  logic rst;

  // Instance A: N=8, W=1
  logic [7:0]  d_a;
  logic [2:0]  sel_a;
  logic        mode_a, start_a, rdy_a;
  logic [0:0]  y_a;
  logic        yv_a, busy_a, done_a;
  logic [2:0]  ych_a;

  // Instance B: N=4, W=8
  logic [31:0] d_b;
  logic [1:0]  sel_b;
  logic        mode_b, start_b, rdy_b;
  logic [7:0]  y_b;
  logic        yv_b, busy_b, done_b;
  logic [1:0]  ych_b;

  // Instance C: N=5, W=4 (sel can exceed N-1)
  logic [19:0] d_c;
  logic [2:0]  sel_c;
  logic        mode_c, start_c, rdy_c;
  logic [3:0]  y_c;
  logic        yv_c, busy_c, done_c;
  logic [2:0]  ych_c;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [15:0] q_a[$];
  logic [15:0] q_b[$];
  logic [15:0] q_c[$];

  mux_n_scan #(.N(8), .W(1)) dut_a (
    .clk(clk), .rst(rst), .d(d_a), .sel(sel_a), .mode(mode_a), .start(start_a),
    .out_ready(rdy_a), .y(y_a), .y_valid(yv_a), .y_ch(ych_a), .busy(busy_a), .done(done_a)
  );

  mux_n_scan #(.N(4), .W(8)) dut_b (
    .clk(clk), .rst(rst), .d(d_b), .sel(sel_b), .mode(mode_b), .start(start_b),
    .out_ready(rdy_b), .y(y_b), .y_valid(yv_b), .y_ch(ych_b), .busy(busy_b), .done(done_b)
  );

  mux_n_scan #(.N(5), .W(4)) dut_c (
    .clk(clk), .rst(rst), .d(d_c), .sel(sel_c), .mode(mode_c), .start(start_c),
    .out_ready(rdy_c), .y(y_c), .y_valid(yv_c), .y_ch(ych_c), .busy(busy_c), .done(done_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    d_a = 8'hFF; sel_a = 3'd3; mode_a = 1'b0; rdy_a = 1'b1; start_a = 1'b0;
    d_b = 32'hFFFF_FFFF; mode_b = 1'b1; start_b = 1'b1; rdy_b = 1'b1; sel_b = 2'd0;
    d_c = 20'hFFFFF; sel_c = 3'd1; mode_c = 1'b0; start_c = 1'b0; rdy_c = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({y_a, ych_a, yv_a, busy_a, done_a} !== 7'd0)
      $display("FAIL reset_a: got %b expected 0", {y_a, ych_a, yv_a, busy_a, done_a});
    else pass_cnt++;
    total_cnt++;
    if ({y_b, ych_b, yv_b, busy_b, done_b} !== 13'd0)
      $display("FAIL reset_b: got %b expected 0", {y_b, ych_b, yv_b, busy_b, done_b});
    else pass_cnt++;
    total_cnt++;
    if ({y_c, ych_c, yv_c} !== 8'd0)
      $display("FAIL reset_c: got %b expected 0", {y_c, ych_c, yv_c});
    else pass_cnt++;
    rst = 1'b0;
    start_b = 1'b0;
    mode_b = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({yv_a, ych_a, y_a} !== {1'b1, 3'd3, 1'b1})
      $display("FAIL first_load_a: got %b expected %b", {yv_a, ych_a, y_a}, {1'b1, 3'd3, 1'b1});
    else pass_cnt++;
  endtask

  task automatic test_static();
    logic        tbl [8];
    logic [15:0] exp;
    tbl = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    mode_a = 1'b0; rdy_a = 1'b1; d_a = 8'b1010_0110;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      sel_a = 3'(s);
      q_a.push_back({4'd0, 8'(s), 3'd0, tbl[s]});
      @(posedge clk); #1;
      exp = q_a.pop_front();
      total_cnt++;
      if ({4'd0, 5'd0, ych_a, 3'd0, y_a} !== exp || yv_a !== 1'b1)
        $display("FAIL static_sel%0d: got ch=%0d y=%0d v=%0d expected ch=%0d y=%0d v=1",
                 s, ych_a, y_a, yv_a, exp[11:4], exp[0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_static_hold();
    @(negedge clk);
    rdy_a = 1'b0; sel_a = 3'd2;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({yv_a, ych_a, y_a} !== {1'b1, 3'd7, 1'b1})
      $display("FAIL static_hold: got %b expected %b", {yv_a, ych_a, y_a}, {1'b1, 3'd7, 1'b1});
    else pass_cnt++;
    @(negedge clk);
    rdy_a = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({yv_a, ych_a, y_a} !== {1'b1, 3'd2, 1'b1})
      $display("FAIL static_release: got %b expected %b", {yv_a, ych_a, y_a}, {1'b1, 3'd2, 1'b1});
    else pass_cnt++;
  endtask

  task automatic test_static_oob();
    logic [15:0] exp;
    @(negedge clk);
    d_c = 20'hABCDE; mode_c = 1'b0; rdy_c = 1'b1;
    for (int s = 4; s < 8; s++) begin
      @(negedge clk);
      sel_c = 3'(s);
      q_c.push_back({8'(s), 4'd0, (s == 4) ? 4'hA : 4'h0});
      @(posedge clk); #1;
      exp = q_c.pop_front();
      total_cnt++;
      if ({5'd0, ych_c, 4'd0, y_c} !== exp || yv_c !== 1'b1)
        $display("FAIL oob_sel%0d: got ch=%0d y=%h v=%0d expected ch=%0d y=%h v=1",
                 s, ych_c, y_c, yv_c, exp[15:8], exp[3:0]);
      else pass_cnt++;
    end
  endtask

  task automatic prep_scan();
    @(negedge clk);
    mode_b = 1'b1; rdy_b = 1'b1; start_b = 1'b0;
    d_b = {8'h44, 8'h33, 8'h22, 8'h11};
    repeat (2) @(negedge clk);
    total_cnt++;
    if (yv_b !== 1'b0 || busy_b !== 1'b0)
      $display("FAIL scan_idle_drain: got v=%0d busy=%0d expected 0 0", yv_b, busy_b);
    else pass_cnt++;
  endtask

  task automatic run_sweep(input int stall_cycles, input bit restart_mid, input string name);
    logic [7:0]  tbl [4];
    logic [15:0] exp;
    int beats, dones, busy_cyc, stall_left, cyc;
    tbl = '{8'h11, 8'h22, 8'h33, 8'h44};
    beats = 0; dones = 0; busy_cyc = 0; stall_left = stall_cycles; cyc = 0;
    prep_scan();
    start_b = 1'b1;
    for (int k = 0; k < 4; k++) q_b.push_back({8'(k), tbl[k]});
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      start_b = (restart_mid && beats == 2) ? 1'b1 : 1'b0;
      if (busy_b) busy_cyc++;
      if (done_b) dones++;
      if (yv_b) begin
        total_cnt++;
        if (q_b.size() == 0) begin
          $display("FAIL %s_extra_beat: got ch=%0d y=%h expected none", name, ych_b, y_b);
          rdy_b = 1'b1;
        end else begin
          exp = q_b[0];
          if ({6'd0, ych_b, y_b} !== exp)
            $display("FAIL %s_beat: got ch=%0d y=%h expected ch=%0d y=%h",
                     name, ych_b, y_b, exp[15:8], exp[7:0]);
          else pass_cnt++;
          if (stall_left > 0 && ych_b == 2'd1) begin
            rdy_b = 1'b0;
            stall_left--;
            d_b[15:8] = 8'hEE;
          end else begin
            rdy_b = 1'b1;
            d_b[15:8] = 8'h22;
            void'(q_b.pop_front());
            beats++;
          end
        end
      end else begin
        rdy_b = 1'b1;
      end
      if (beats == 4 && !busy_b && !yv_b) break;
    end
    start_b = 1'b0;
    total_cnt++;
    if (cyc >= 40) $display("FAIL %s_timeout: got %0d cycles expected under 40", name, cyc);
    else pass_cnt++;
    total_cnt++;
    if (beats != 4) $display("FAIL %s_beats: got %0d expected 4", name, beats);
    else pass_cnt++;
    total_cnt++;
    if (dones != 1) $display("FAIL %s_done: got %0d expected 1", name, dones);
    else pass_cnt++;
    total_cnt++;
    if (busy_cyc != 5 + stall_cycles)
      $display("FAIL %s_busy: got %0d expected %0d", name, busy_cyc, 5 + stall_cycles);
    else pass_cnt++;
    total_cnt++;
    if (yv_b !== 1'b0) $display("FAIL %s_final_valid: got %0d expected 0", name, yv_b);
    else pass_cnt++;
    q_b.delete();
  endtask

  task automatic wait_second_beat(input string name);
    int cyc;
    cyc = 0;
    while (!(yv_b && ych_b == 2'd1) && cyc < 20) begin
      @(negedge clk);
      start_b = 1'b0;
      cyc++;
    end
    total_cnt++;
    if (cyc >= 20) $display("FAIL %s_wait: got timeout expected second beat", name);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    prep_scan();
    start_b = 1'b1;
    @(negedge clk);
    wait_second_beat("abort");
    mode_b = 1'b0; sel_b = 2'd2; rdy_b = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({busy_b, done_b, yv_b} !== 3'b000)
      $display("FAIL abort_idle: got busy=%0d done=%0d v=%0d expected 0 0 0", busy_b, done_b, yv_b);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({yv_b, ych_b, y_b} !== {1'b1, 2'd2, 8'h33})
      $display("FAIL abort_static: got v=%0d ch=%0d y=%h expected 1 2 33", yv_b, ych_b, y_b);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_sweep();
    int dones, valids;
    dones = 0; valids = 0;
    @(negedge clk);
    mode_a = 1'b0; rdy_a = 1'b1; sel_a = 3'd7; d_a = 8'b1010_0110;
    sel_c = 3'd7; rdy_c = 1'b1;
    prep_scan();
    start_b = 1'b1;
    @(negedge clk);
    wait_second_beat("rst_mid");
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({y_b, ych_b, yv_b, busy_b, done_b} !== 13'd0)
      $display("FAIL rst_mid_b: got %b expected 0", {y_b, ych_b, yv_b, busy_b, done_b});
    else pass_cnt++;
    total_cnt++;
    if ({y_a, ych_a, yv_a} !== 5'd0)
      $display("FAIL rst_mid_a: got %b expected 0", {y_a, ych_a, yv_a});
    else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done_b) dones++;
      if (yv_b) valids++;
    end
    total_cnt++;
    if (dones != 0 || valids != 0)
      $display("FAIL rst_mid_quiet: got done=%0d valid=%0d expected 0 0", dones, valids);
    else pass_cnt++;
    total_cnt++;
    if ({yv_a, ych_a, y_a} !== {1'b1, 3'd7, 1'b1})
      $display("FAIL rst_mid_static_a: got %b expected %b", {yv_a, ych_a, y_a}, {1'b1, 3'd7, 1'b1});
    else pass_cnt++;
    total_cnt++;
    if ({yv_c, ych_c, y_c} !== {1'b1, 3'd7, 4'h0})
      $display("FAIL rst_mid_oob_c: got %b expected %b", {yv_c, ych_c, y_c}, {1'b1, 3'd7, 4'h0});
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    d_a = '0; sel_a = '0; mode_a = 1'b0; start_a = 1'b0; rdy_a = 1'b1;
    d_b = '0; sel_b = '0; mode_b = 1'b0; start_b = 1'b0; rdy_b = 1'b1;
    d_c = '0; sel_c = '0; mode_c = 1'b0; start_c = 1'b0; rdy_c = 1'b1;
    test_reset();
    test_static();
    test_static_hold();
    test_static_oob();
    run_sweep(0, 1'b0, "sweep");
    run_sweep(3, 1'b0, "backpressure");
    run_sweep(0, 1'b1, "restart");
    test_abort();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
